// File: rtl/controlfsm.sv
// rtl/controlfsm.sv - multicycle MIPS main control FSM; optional LI path under CONTROLFSM_LI_EN
module controlfsm (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic       memready,
    output logic       pcwrite,
    output logic       branch,
    output logic       irwrite,
    output logic       memwrite,
    output logic       regwrite,
    output logic       iord,
    output logic       memtoreg,
    output logic       regdst,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic [1:0] pcsrc,
    output logic [1:0] aluop,
    output logic       illegal
);

    typedef enum logic [3:0] {
        FETCH   = 4'd0,
        DECODE  = 4'd1,
        MEMADR  = 4'd2,
        MEMRD   = 4'd3,
        MEMWB   = 4'd4,
        MEMWR   = 4'd5,
        RTYPEEX = 4'd6,
        RTYPEWB = 4'd7,
        BEQEX   = 4'd8,
        ADDIEX  = 4'd9,
        ADDIWB  = 4'd10,
        JEX     = 4'd11,
        LIEX    = 4'd12,
        LIWB    = 4'd13
    } state_t;

    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_LI    = 6'b001111;

    state_t     state_q, state_d;
    logic       pcwrite_q, branch_q, memwrite_q, regwrite_q;
    logic       iord_q, memtoreg_q, regdst_q, alusrca_q;
    logic [1:0] alusrcb_q, pcsrc_q, aluop_q;
    logic       legal_op;

    always_comb begin
        legal_op = 1'b1;
        case (op)
            OP_LW, OP_SW, OP_RTYPE, OP_BEQ, OP_ADDI, OP_J: legal_op = 1'b1;
`ifdef CONTROLFSM_LI_EN
            OP_LI:   legal_op = 1'b1;
`endif
            default: legal_op = 1'b0;
        endcase
    end

    always_comb begin
        state_d = FETCH;
        case (state_q)
            FETCH:   state_d = memready ? DECODE : FETCH;
            DECODE: begin
                case (op)
                    OP_LW, OP_SW: state_d = MEMADR;
                    OP_RTYPE:     state_d = RTYPEEX;
                    OP_BEQ:       state_d = BEQEX;
                    OP_ADDI:      state_d = ADDIEX;
                    OP_J:         state_d = JEX;
`ifdef CONTROLFSM_LI_EN
                    OP_LI:        state_d = LIEX;
`endif
                    default:      state_d = FETCH;
                endcase
            end
            MEMADR:  state_d = (op == OP_SW) ? MEMWR : MEMRD;
            MEMRD:   state_d = memready ? MEMWB : MEMRD;
            MEMWR:   state_d = memready ? FETCH : MEMWR;
            RTYPEEX: state_d = RTYPEWB;
            ADDIEX:  state_d = ADDIWB;
`ifdef CONTROLFSM_LI_EN
            LIEX:    state_d = LIWB;
`endif
            default: state_d = FETCH;
        endcase
    end

    // Moore outputs are registered from the next state so they line up with state_q.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= FETCH;
            pcwrite_q  <= 1'b0;
            branch_q   <= 1'b0;
            memwrite_q <= 1'b0;
            regwrite_q <= 1'b0;
            iord_q     <= 1'b0;
            memtoreg_q <= 1'b0;
            regdst_q   <= 1'b0;
            alusrca_q  <= 1'b0;
            alusrcb_q  <= 2'b01;
            pcsrc_q    <= 2'b00;
            aluop_q    <= 2'b00;
        end else begin
            state_q    <= state_d;
            pcwrite_q  <= 1'b0;
            branch_q   <= 1'b0;
            memwrite_q <= 1'b0;
            regwrite_q <= 1'b0;
            iord_q     <= 1'b0;
            memtoreg_q <= 1'b0;
            regdst_q   <= 1'b0;
            alusrca_q  <= 1'b0;
            alusrcb_q  <= 2'b00;
            pcsrc_q    <= 2'b00;
            aluop_q    <= 2'b00;
            case (state_d)
                FETCH:   alusrcb_q <= 2'b01;
                DECODE:  alusrcb_q <= 2'b11;
                MEMADR: begin
                    alusrca_q <= 1'b1;
                    alusrcb_q <= 2'b10;
                end
                MEMRD:   iord_q <= 1'b1;
                MEMWB: begin
                    regwrite_q <= 1'b1;
                    memtoreg_q <= 1'b1;
                end
                MEMWR: begin
                    iord_q     <= 1'b1;
                    memwrite_q <= 1'b1;
                end
                RTYPEEX: begin
                    alusrca_q <= 1'b1;
                    aluop_q   <= 2'b10;
                end
                RTYPEWB: begin
                    regwrite_q <= 1'b1;
                    regdst_q   <= 1'b1;
                end
                BEQEX: begin
                    alusrca_q <= 1'b1;
                    aluop_q   <= 2'b01;
                    pcsrc_q   <= 2'b01;
                    branch_q  <= 1'b1;
                end
                ADDIEX: begin
                    alusrca_q <= 1'b1;
                    alusrcb_q <= 2'b10;
                end
                ADDIWB:  regwrite_q <= 1'b1;
                JEX: begin
                    pcsrc_q   <= 2'b10;
                    pcwrite_q <= 1'b1;
                end
`ifdef CONTROLFSM_LI_EN
                LIEX: begin
                    alusrca_q <= 1'b1;
                    alusrcb_q <= 2'b10;
                    aluop_q   <= 2'b11;
                end
                LIWB:    regwrite_q <= 1'b1;
`endif
                default: ;
            endcase
        end
    end

    assign irwrite  = (state_q == FETCH) && memready && !reset;
    assign pcwrite  = pcwrite_q || irwrite;
    assign illegal  = (state_q == DECODE) && !legal_op;
    assign branch   = branch_q;
    assign memwrite = memwrite_q;
    assign regwrite = regwrite_q;
    assign iord     = iord_q;
    assign memtoreg = memtoreg_q;
    assign regdst   = regdst_q;
    assign alusrca  = alusrca_q;
    assign alusrcb  = alusrcb_q;
    assign pcsrc    = pcsrc_q;
    assign aluop    = aluop_q;

endmodule

// File: tb/tb_controlfsm.sv
// tb/tb_controlfsm.sv - scoreboard bench for controlfsm; honours CONTROLFSM_LI_EN
module tb_controlfsm;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [5:0] op = 6'd0;
    logic       memready = 1'b1;
    logic       pcwrite, branch, irwrite, memwrite, regwrite, iord, memtoreg, regdst, alusrca, illegal;
    logic [1:0] alusrcb, pcsrc, aluop;

    controlfsm dut (
        .clk(clk), .reset(reset), .op(op), .memready(memready),
        .pcwrite(pcwrite), .branch(branch), .irwrite(irwrite), .memwrite(memwrite),
        .regwrite(regwrite), .iord(iord), .memtoreg(memtoreg), .regdst(regdst),
        .alusrca(alusrca), .alusrcb(alusrcb), .pcsrc(pcsrc), .aluop(aluop), .illegal(illegal)
    );

    always #5 clk = ~clk;

    // {pcwrite,branch,irwrite,memwrite,regwrite,iord,memtoreg,regdst,alusrca,alusrcb,pcsrc,aluop,illegal}
    function automatic logic [15:0] mk(input logic pcw, br, irw, mw, rw, io, m2r, rd, asa,
                                       input logic [1:0] asb, pcs, aop, input logic ill);
        return {pcw, br, irw, mw, rw, io, m2r, rd, asa, asb, pcs, aop, ill};
    endfunction

    localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000, BEQ = 6'b000100;
    localparam logic [5:0] ADDI = 6'b001000, J = 6'b000010, LI = 6'b001111, BAD = 6'b111000;

    logic [15:0] E_RST, E_F1, E_F0, E_DEC, E_DECI, E_MA, E_MR, E_MWB, E_MW, E_REX, E_RWB;
    logic [15:0] E_BEQ, E_AEX, E_AWB, E_JEX, E_LIEX, E_LIWB;

    logic [15:0] expq[$];
    string       nameq[$];
    int          checks = 0;
    int          fails = 0;

    task automatic step(input logic rst_v, input logic [5:0] op_v, input logic mr_v,
                        input logic [15:0] exp_v, input string nm);
        @(posedge clk);
        #1;
        reset    = rst_v;
        op       = op_v;
        memready = mr_v;
        expq.push_back(exp_v);
        nameq.push_back(nm);
    endtask

    always @(negedge clk) begin
        if (expq.size() > 0) begin
            logic [15:0] e, g;
            string n;
            e = expq.pop_front();
            n = nameq.pop_front();
            g = {pcwrite, branch, irwrite, memwrite, regwrite, iord, memtoreg, regdst,
                 alusrca, alusrcb, pcsrc, aluop, illegal};
            checks++;
            if (g !== e) begin
                fails++;
                $display("FAIL %s: got %b expected %b", n, g, e);
            end
        end
    end

    initial begin
        E_RST  = mk(0,0,0,0,0,0,0,0,0,2'b01,2'b00,2'b00,0);
        E_F1   = mk(1,0,1,0,0,0,0,0,0,2'b01,2'b00,2'b00,0);
        E_F0   = mk(0,0,0,0,0,0,0,0,0,2'b01,2'b00,2'b00,0);
        E_DEC  = mk(0,0,0,0,0,0,0,0,0,2'b11,2'b00,2'b00,0);
        E_DECI = mk(0,0,0,0,0,0,0,0,0,2'b11,2'b00,2'b00,1);
        E_MA   = mk(0,0,0,0,0,0,0,0,1,2'b10,2'b00,2'b00,0);
        E_MR   = mk(0,0,0,0,0,1,0,0,0,2'b00,2'b00,2'b00,0);
        E_MWB  = mk(0,0,0,0,1,0,1,0,0,2'b00,2'b00,2'b00,0);
        E_MW   = mk(0,0,0,1,0,1,0,0,0,2'b00,2'b00,2'b00,0);
        E_REX  = mk(0,0,0,0,0,0,0,0,1,2'b00,2'b00,2'b10,0);
        E_RWB  = mk(0,0,0,0,1,0,0,1,0,2'b00,2'b00,2'b00,0);
        E_BEQ  = mk(0,1,0,0,0,0,0,0,1,2'b00,2'b01,2'b01,0);
        E_AEX  = mk(0,0,0,0,0,0,0,0,1,2'b10,2'b00,2'b00,0);
        E_AWB  = mk(0,0,0,0,1,0,0,0,0,2'b00,2'b00,2'b00,0);
        E_JEX  = mk(1,0,0,0,0,0,0,0,0,2'b00,2'b10,2'b00,0);
        E_LIEX = mk(0,0,0,0,0,0,0,0,1,2'b10,2'b00,2'b11,0);
        E_LIWB = mk(0,0,0,0,1,0,0,0,0,2'b00,2'b00,2'b00,0);

        step(1, LW, 1, E_RST, "reset_hold0");
        step(1, LW, 1, E_RST, "reset_hold1");
        // lw, 5 cycles
        step(0, LW, 1, E_F1,  "lw_fetch");
        step(0, LW, 1, E_DEC, "lw_decode");
        step(0, LW, 1, E_MA,  "lw_memadr");
        step(0, LW, 1, E_MR,  "lw_memrd");
        step(0, LW, 1, E_MWB, "lw_memwb");
        // sw, 4 cycles
        step(0, SW, 1, E_F1,  "sw_fetch");
        step(0, SW, 1, E_DEC, "sw_decode");
        step(0, SW, 1, E_MA,  "sw_memadr");
        step(0, SW, 1, E_MW,  "sw_memwr");
        // R-type
        step(0, RT, 1, E_F1,  "rt_fetch");
        step(0, RT, 1, E_DEC, "rt_decode");
        step(0, RT, 1, E_REX, "rt_ex");
        step(0, RT, 1, E_RWB, "rt_wb");
        // beq
        step(0, BEQ, 1, E_F1,  "beq_fetch");
        step(0, BEQ, 1, E_DEC, "beq_decode");
        step(0, BEQ, 1, E_BEQ, "beq_ex");
        // addi
        step(0, ADDI, 1, E_F1,  "addi_fetch");
        step(0, ADDI, 1, E_DEC, "addi_decode");
        step(0, ADDI, 1, E_AEX, "addi_ex");
        step(0, ADDI, 1, E_AWB, "addi_wb");
        // fetch stalled 3 cycles, then j
        step(0, J, 0, E_F0,  "fetch_wait0");
        step(0, J, 0, E_F0,  "fetch_wait1");
        step(0, J, 0, E_F0,  "fetch_wait2");
        step(0, J, 1, E_F1,  "fetch_go");
        step(0, J, 1, E_DEC, "j_decode");
        step(0, J, 1, E_JEX, "j_ex");
        // sw with 2 wait cycles in MEMWR
        step(0, SW, 1, E_F1,  "sww_fetch");
        step(0, SW, 1, E_DEC, "sww_decode");
        step(0, SW, 1, E_MA,  "sww_memadr");
        step(0, SW, 0, E_MW,  "sww_memwr0");
        step(0, SW, 0, E_MW,  "sww_memwr1");
        step(0, SW, 1, E_MW,  "sww_memwr2");
        // lw with 1 wait cycle in MEMRD
        step(0, LW, 1, E_F1,  "lww_fetch");
        step(0, LW, 1, E_DEC, "lww_decode");
        step(0, LW, 1, E_MA,  "lww_memadr");
        step(0, LW, 0, E_MR,  "lww_memrd0");
        step(0, LW, 1, E_MR,  "lww_memrd1");
        step(0, LW, 1, E_MWB, "lww_memwb");
        // unsupported opcode
        step(0, BAD, 1, E_F1,   "bad_fetch");
        step(0, BAD, 1, E_DECI, "bad_decode");
        // LI opcode
        step(0, LI, 1, E_F1, "li_fetch");
`ifdef CONTROLFSM_LI_EN
        step(0, LI, 1, E_DEC,  "li_decode");
        step(0, LI, 1, E_LIEX, "li_ex");
        step(0, LI, 1, E_LIWB, "li_wb");
`else
        step(0, LI, 1, E_DECI, "li_decode_illegal");
`endif
        // reset asserted mid-MEMWR must kill memwrite without a clock edge
        step(0, SW, 1, E_F1,  "swr_fetch");
        step(0, SW, 1, E_DEC, "swr_decode");
        step(0, SW, 1, E_MA,  "swr_memadr");
        step(0, SW, 0, E_MW,  "swr_memwr");
        step(1, SW, 0, E_RST, "swr_reset_async");
        step(0, RT, 1, E_F1,  "after_reset_fetch");
        step(0, RT, 1, E_DEC, "after_reset_decode");

        for (int i = 0; i < 20 && expq.size() > 0; i++) @(posedge clk);
        checks++;
        if (expq.size() != 0) begin
            fails++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", expq.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
